register_bank: RTL and testbench

Parametrised bank of DEPTH edge-triggered registers, each WIDTH bits wide, with one write port and two combinational read ports. It is the clocked, multi-word successor to the single-bit store-enable latch. It replaces ad-hoc per-register instances in the datapath (A/D/general-purpose registers) with one addressable block. An optional write-to-read bypass reproduces latch-style transparency on the same cycle as a store, and a synchronous clear plus per-entry written flags support initialisation checks.

---
 rtl/register_bank.sv | 117 +++++++++++
 tb/tb_register_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH bank of edge-triggered registers with one write
// port and two combinational read ports. It keeps per-entry written flags, has a
// synchronous clear, and can optionally bypass write data straight to a read port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; entries go to RESET_VALUE
//   st         store enable; d is written to entry wr_addr at the edge
//   wr_addr    write address (AW bits)
//   d          write data (WIDTH bits)
//   clr        synchronous clear of all entries and written flags; wins over st
//   rd_addr_a  read address, port A
//   rd_addr_b  read address, port B
//   q_a, q_b   combinational read data; 0 for addresses >= DEPTH
//   written    bit i set once entry i has been stored since reset or clear
//   wr_err     registered one-cycle pulse after a store to an address >= DEPTH
module register_bank #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      DEPTH       = 8,
    parameter bit               BYPASS      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int unsigned     AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d,
    input  logic             clr,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic [DEPTH-1:0] written,
    output logic             wr_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;
    logic             wr_err_q;
    logic             wr_err_d;

    logic             wr_in_range_c;
    logic             rd_a_in_range_c;
    logic             rd_b_in_range_c;
    logic             store_c;

    // Range checks only matter when DEPTH is not a power of two.
    assign wr_in_range_c   = (32'(wr_addr)   < DEPTH);
    assign rd_a_in_range_c = (32'(rd_addr_a) < DEPTH);
    assign rd_b_in_range_c = (32'(rd_addr_b) < DEPTH);

    // A store only takes effect when not overridden by clear.
    assign store_c = st && !clr && wr_in_range_c;

    // Next-state for the written flags and the error pulse.
    always_comb begin
        written_d = written_q;
        wr_err_d  = st && !wr_in_range_c;
        if (clr) begin
            written_d = '0;
        end else if (store_c) begin
            written_d[wr_addr] = 1'b1;
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
        end else if (store_c) begin
            mem_q[wr_addr] <= d;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            written_q <= written_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Read ports; bypass is gated by rst_n so reset always shows RESET_VALUE.
    always_comb begin
        q_a = '0;
        q_b = '0;
        if (rd_a_in_range_c) begin
            q_a = mem_q[rd_addr_a];
        end
        if (rd_b_in_range_c) begin
            q_b = mem_q[rd_addr_b];
        end
        if (BYPASS && rst_n && store_c) begin
            if (rd_addr_a == wr_addr) begin
                q_a = d;
            end
            if (rd_addr_b == wr_addr) begin
                q_b = d;
            end
        end
    end

    assign written = written_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank. Three instances share one stimulus:
// u_dut (DEPTH=8, BYPASS=1), u_nb (DEPTH=8, BYPASS=0) and u_d6 (DEPTH=6, BYPASS=1).
module tb_register_bank;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  passed = 0;
    int  total  = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st;
    logic        clr;
    logic [2:0]  wr_addr;
    logic [15:0] d;
    logic [2:0]  rd_a;
    logic [2:0]  rd_b;

    logic [15:0] qa8, qb8, qan, qbn, qa6, qb6;
    logic [7:0]  wr8, wrn;
    logic [5:0]  wr6;
    logic        err8, errn, err6;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .RESET_VALUE(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .st(st), .wr_addr(wr_addr), .d(d), .clr(clr),
        .rd_addr_a(rd_a), .rd_addr_b(rd_b), .q_a(qa8), .q_b(qb8),
        .written(wr8), .wr_err(err8)
    );

    register_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .RESET_VALUE(16'h0000)) u_nb (
        .clk(clk), .rst_n(rst_n), .st(st), .wr_addr(wr_addr), .d(d), .clr(clr),
        .rd_addr_a(rd_a), .rd_addr_b(rd_b), .q_a(qan), .q_b(qbn),
        .written(wrn), .wr_err(errn)
    );

    register_bank #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b1), .RESET_VALUE(16'h0000)) u_d6 (
        .clk(clk), .rst_n(rst_n), .st(st), .wr_addr(wr_addr), .d(d), .clr(clr),
        .rd_addr_a(rd_a), .rd_addr_b(rd_b), .q_a(qa6), .q_b(qb6),
        .written(wr6), .wr_err(err6)
    );

    task automatic test_reset();
        sb_t e;
        rst_n = 1'b0; st = 1'b0; clr = 1'b0; wr_addr = '0; d = '0; rd_a = '0; rd_b = '0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            rd_a = 3'(a);
            rd_b = 3'(7 - a);
            sb.push_back('{name: $sformatf("reset_qa[%0d]", a), exp: 16'h0000});
            sb.push_back('{name: $sformatf("reset_qb[%0d]", 7 - a), exp: 16'h0000});
            #1;
            e = sb.pop_front(); total++;
            if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
            e = sb.pop_front(); total++;
            if (qb8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qb8, e.exp); else passed++;
        end
        sb.push_back('{name: "reset_written", exp: 16'h0000});
        sb.push_back('{name: "reset_wr_err", exp: 16'h0000});
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(err8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, err8, e.exp); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        sb_t e;
        @(negedge clk);
        st = 1'b1; wr_addr = 3'd3; d = 16'hBEEF;
        @(negedge clk);
        st = 1'b0; rd_a = 3'd3;
        sb.push_back('{name: "store_qa", exp: 16'hBEEF});
        sb.push_back('{name: "store_written8", exp: 16'h0008});
        sb.push_back('{name: "store_written_nb", exp: 16'h0008});
        sb.push_back('{name: "store_written6", exp: 16'h0008});
        #1;
        e = sb.pop_front(); total++;
        if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(wrn) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wrn, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(wr6) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr6, e.exp); else passed++;
    endtask

    task automatic test_hold();
        sb_t e;
        rd_a = 3'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            d = c[0] ? 16'hFFFF : 16'h0000;
            wr_addr = 3'(c);
            sb.push_back('{name: $sformatf("hold_qa[%0d]", c), exp: 16'hBEEF});
            sb.push_back('{name: $sformatf("hold_written[%0d]", c), exp: 16'h0008});
            #1;
            e = sb.pop_front(); total++;
            if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
            e = sb.pop_front(); total++;
            if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        end
    endtask

    task automatic test_bypass();
        sb_t e;
        @(negedge clk);
        st = 1'b1; wr_addr = 3'd5; d = 16'h1234; rd_a = 3'd5; rd_b = 3'd3;
        sb.push_back('{name: "byp_qa", exp: 16'h1234});
        sb.push_back('{name: "byp_qb", exp: 16'hBEEF});
        sb.push_back('{name: "nobyp_qa_pre", exp: 16'h0000});
        sb.push_back('{name: "nobyp_qb", exp: 16'hBEEF});
        #1;
        e = sb.pop_front(); total++;
        if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qb8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qb8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qan !== e.exp) $display("FAIL %s: got %h want %h", e.name, qan, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qbn !== e.exp) $display("FAIL %s: got %h want %h", e.name, qbn, e.exp); else passed++;
        @(posedge clk);
        sb.push_back('{name: "nobyp_qa_post", exp: 16'h1234});
        #1;
        e = sb.pop_front(); total++;
        if (qan !== e.exp) $display("FAIL %s: got %h want %h", e.name, qan, e.exp); else passed++;
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic test_clear();
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            st = 1'b1; wr_addr = 3'(i); d = 16'h1000 + 16'(i);
        end
        @(negedge clk);
        st = 1'b0;
        sb.push_back('{name: "fill_written", exp: 16'h00FF});
        #1;
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        // Clear with a simultaneous store: bypass must not apply.
        clr = 1'b1; st = 1'b1; wr_addr = 3'd2; d = 16'hAAAA; rd_a = 3'd2; rd_b = 3'd7;
        sb.push_back('{name: "clr_pre_qa", exp: 16'h1002});
        sb.push_back('{name: "clr_pre_qb", exp: 16'h1007});
        #1;
        e = sb.pop_front(); total++;
        if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qb8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qb8, e.exp); else passed++;
        @(negedge clk);
        clr = 1'b0; st = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_a = 3'(a);
            sb.push_back('{name: $sformatf("clr_qa[%0d]", a), exp: 16'h0000});
            #1;
            e = sb.pop_front(); total++;
            if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        end
        sb.push_back('{name: "clr_written", exp: 16'h0000});
        sb.push_back('{name: "clr_wr_err8", exp: 16'h0000});
        sb.push_back('{name: "clr_wr_err6", exp: 16'h0000});
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(err8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, err8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(err6) !== e.exp) $display("FAIL %s: got %h want %h", e.name, err6, e.exp); else passed++;
    endtask

    task automatic test_out_of_range();
        sb_t e;
        @(negedge clk);
        st = 1'b1; wr_addr = 3'd7; d = 16'h5555; rd_a = 3'd7; rd_b = 3'd5;
        sb.push_back('{name: "oor_pre_qa6", exp: 16'h0000});
        sb.push_back('{name: "oor_pre_qb6", exp: 16'h0000});
        #1;
        e = sb.pop_front(); total++;
        if (qa6 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa6, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qb6 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qb6, e.exp); else passed++;
        @(posedge clk);
        sb.push_back('{name: "oor_wr_err6", exp: 16'h0001});
        sb.push_back('{name: "oor_wr_err8", exp: 16'h0000});
        #1;
        e = sb.pop_front(); total++;
        if (16'(err6) !== e.exp) $display("FAIL %s: got %h want %h", e.name, err6, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(err8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, err8, e.exp); else passed++;
        @(negedge clk);
        st = 1'b0;
        sb.push_back('{name: "oor_written6", exp: 16'h0000});
        #1;
        e = sb.pop_front(); total++;
        if (16'(wr6) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr6, e.exp); else passed++;
        @(posedge clk);
        sb.push_back('{name: "oor_wr_err6_drop", exp: 16'h0000});
        #1;
        e = sb.pop_front(); total++;
        if (16'(err6) !== e.exp) $display("FAIL %s: got %h want %h", e.name, err6, e.exp); else passed++;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            rd_a = 3'(a);
            sb.push_back('{name: $sformatf("oor_qa6[%0d]", a), exp: 16'h0000});
            #1;
            e = sb.pop_front(); total++;
            if (qa6 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa6, e.exp); else passed++;
        end
    endtask

    task automatic test_async_reset();
        sb_t e;
        @(negedge clk);
        st = 1'b1; wr_addr = 3'd1; d = 16'h4321;
        @(negedge clk);
        st = 1'b0; rd_a = 3'd1; rd_b = 3'd7;
        sb.push_back('{name: "ar_pre_qa", exp: 16'h4321});
        sb.push_back('{name: "ar_pre_qb", exp: 16'h5555});
        sb.push_back('{name: "ar_pre_written", exp: 16'h0082});
        #1;
        e = sb.pop_front(); total++;
        if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qb8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qb8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.push_back('{name: "ar_qa", exp: 16'h0000});
        sb.push_back('{name: "ar_qb", exp: 16'h0000});
        sb.push_back('{name: "ar_written", exp: 16'h0000});
        sb.push_back('{name: "ar_qa_nb", exp: 16'h0000});
        #1;
        e = sb.pop_front(); total++;
        if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qb8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qb8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qan !== e.exp) $display("FAIL %s: got %h want %h", e.name, qan, e.exp); else passed++;
        @(negedge clk);
        rst_n = 1'b1; st = 1'b1; wr_addr = 3'd6; d = 16'h7777; rd_a = 3'd6;
        @(negedge clk);
        st = 1'b0;
        sb.push_back('{name: "ar_post_qa", exp: 16'h7777});
        sb.push_back('{name: "ar_post_written", exp: 16'h0040});
        sb.push_back('{name: "ar_post_qa_nb", exp: 16'h7777});
        #1;
        e = sb.pop_front(); total++;
        if (qa8 !== e.exp) $display("FAIL %s: got %h want %h", e.name, qa8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (16'(wr8) !== e.exp) $display("FAIL %s: got %h want %h", e.name, wr8, e.exp); else passed++;
        e = sb.pop_front(); total++;
        if (qan !== e.exp) $display("FAIL %s: got %h want %h", e.name, qan, e.exp); else passed++;
    endtask

    initial begin
        test_reset();
        test_store();
        test_hold();
        test_bypass();
        test_clear();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
